// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port W1 arbiter for the integer writeback and the FP result stream.
// The integer writeback always wins the port. FP results wait in a small FIFO, and a
// scoreboard tracks which destination registers still have an FP write outstanding.
// Optional feature: define IBEX_RF_WB_BYPASS_EN to let an FP result write the port in
// the cycle it is accepted when both the FIFO and the integer writeback are idle.
module ibex_rf_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 int_wb_valid_i,
  input  logic [4:0]           int_wb_addr_i,
  input  logic [DataWidth-1:0] int_wb_data_i,
  input  logic                 fp_valid_i,
  input  logic [4:0]           fp_addr_i,
  input  logic [DataWidth-1:0] fp_data_i,
  output logic                 fp_ready_o,
  input  logic                 issue_valid_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic                 fp_pending_o
);

  localparam int unsigned NumRegs = RV32E ? 16 : 32;
  localparam int unsigned PtrW    = $clog2(FifoDepth);
  localparam int unsigned CntW    = $clog2(FifoDepth + 1);

  logic [31:0]          pending_q, pending_d;
  logic [DataWidth-1:0] buf_data_q [FifoDepth];
  logic [4:0]           buf_addr_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic buf_empty_c, buf_full_c;
  logic fp_accept_c, issue_fire_c;
  logic we_c, pop_c, push_c, bypass_c, fp_wr_c;
  logic [4:0]           waddr_c;
  logic [DataWidth-1:0] wdata_c;
  logic int_conflict_c, fp_orphan_c;

  // Pending lookup; x0 and registers outside the implemented file never report pending.
  function automatic logic pend_at(input logic [31:0] pend, input logic [4:0] a);
    return (a != 5'd0) && (32'(a) < NumRegs) && pend[a];
  endfunction

  // Handshake and status flags, all forced low while reset is asserted.
  always_comb begin
    buf_empty_c   = (count_q == CntW'(0));
    buf_full_c    = (count_q == CntW'(FifoDepth));
    fp_ready_o    = rst_ni && !buf_full_c;
    fp_accept_c   = fp_valid_i && fp_ready_o;
    issue_ready_o = rst_ni && !pend_at(pending_q, issue_rd_i);
    issue_fire_c  = issue_valid_i && issue_ready_o;
    hazard_a_o    = rst_ni && pend_at(pending_q, raddr_a_i);
    hazard_b_o    = rst_ni && pend_at(pending_q, raddr_b_i);
    fp_pending_o  = rst_ni && ((|pending_q) || !buf_empty_c);
  end

  // W1 priority: integer writeback, then FIFO head, then (optionally) the live FP result.
  always_comb begin
    we_c     = 1'b0;
    waddr_c  = 5'd0;
    wdata_c  = '0;
    pop_c    = 1'b0;
    bypass_c = 1'b0;
    if (rst_ni) begin
      if (int_wb_valid_i) begin
        we_c    = 1'b1;
        waddr_c = int_wb_addr_i;
        wdata_c = int_wb_data_i;
      end else if (!buf_empty_c) begin
        we_c    = 1'b1;
        waddr_c = buf_addr_q[rd_ptr_q];
        wdata_c = buf_data_q[rd_ptr_q];
        pop_c   = 1'b1;
      end
`ifdef IBEX_RF_WB_BYPASS_EN
      else if (fp_accept_c) begin
        we_c     = 1'b1;
        waddr_c  = fp_addr_i;
        wdata_c  = fp_data_i;
        bypass_c = 1'b1;
      end
`endif
    end
    push_c  = fp_accept_c && !bypass_c;
    fp_wr_c = we_c && !int_wb_valid_i;
  end

  assign we_a_o    = we_c;
  assign waddr_a_o = waddr_c;
  assign wdata_a_o = wdata_c;

  // Scoreboard next state: the FP write retires its bit, an accepted issue marks rd.
  always_comb begin
    pending_d = pending_q;
    if (fp_wr_c) begin
      pending_d[waddr_c] = 1'b0;
    end
    if (issue_fire_c && (issue_rd_i != 5'd0) && (32'(issue_rd_i) < NumRegs)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
  end

  // FIFO pointers, occupancy and scoreboard state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      pending_q <= pending_d;
    end
  end

  // FIFO storage; contents are meaningless once the occupancy is cleared.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      buf_data_q[wr_ptr_q] <= fp_data_i;
      buf_addr_q[wr_ptr_q] <= fp_addr_i;
    end
  end

  // Protocol checks: int write to a pending register, FP result with no outstanding issue.
  always_comb begin
    int_conflict_c = int_wb_valid_i && pend_at(pending_q, int_wb_addr_i);
    fp_orphan_c    = fp_accept_c && !pend_at(pending_q, fp_addr_i);
  end

  a_int_no_pending : assert property (@(posedge clk_i) disable iff (!rst_ni) !int_conflict_c);
  a_fp_was_issued  : assert property (@(posedge clk_i) disable iff (!rst_ni) !fp_orphan_c);

endmodule

// File: doc/ibex_rf_wb_arbiter.md
IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DataWidth, 32, register data width; RV32E, 0, 1 gives 16 scoreboard entries, 0 gives 32; FifoDepth, 2, FP result buffer entries (power of two, >=2).
REQ-002 Ports SHALL be: clk_i  in  1  clock, all state updates on rising edge.
REQ-003 rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
REQ-004 int_wb_valid_i / int_wb_addr_i / int_wb_data_i  in  1/5/DataWidth  integer-pipe writeback; has no ready and is never stalled.
REQ-005 fp_valid_i / fp_addr_i / fp_data_i  in  1/5/DataWidth  multi-cycle FP unit result; fp_ready_o  out  1  accept.
REQ-006 issue_valid_i / issue_rd_i  in  1/5  FP op issue, marks rd pending; issue_ready_o  out  1  issue accepted.
REQ-007 raddr_a_i / raddr_b_i  in  5/5  operand addresses; hazard_a_o / hazard_b_o  out  1/1  operand register pending.
REQ-008 waddr_a_o / wdata_a_o / we_a_o  out  5/DataWidth/1  register-file write port W1.
REQ-009 fp_pending_o  out  1  any scoreboard bit set or buffer non-empty.

Function
REQ-010 Write-port priority per cycle SHALL be: int writeback, then buffer head, then (bypass build only) live FP result.
REQ-011 int_wb_valid_i=1 SHALL drive we_a_o=1 and waddr/wdata from int inputs in the same cycle, zero latency.
REQ-012 FP handshake: transfer when fp_valid_i&&fp_ready_o; fp_ready_o SHALL equal buffer-not-full and not depend on fp_valid_i.
REQ-013 An accepted FP result not written in its cycle SHALL be pushed into the FIFO; head written when the port is free, then popped.
REQ-014 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FifoDepth.
REQ-015 No write cycle SHALL drive we_a_o=0, waddr_a_o=0, wdata_a_o=0.
REQ-016 Scoreboard: one pending bit per register; x0 SHALL never be marked.
REQ-017 issue_ready_o SHALL be 0 when issue_rd_i is already pending, else 1; accepted issue sets bit at next edge.
REQ-018 A pending bit SHALL clear at the edge where the FP write to that address is driven on W1.
REQ-019 hazard_x_o SHALL be pending[raddr_x_i], combinational; address 0 gives 0; RV32E addresses >=16 give 0.
REQ-020 An int writeback to a pending register is a protocol violation; an assertion SHALL fire.
REQ-021 fp_valid_i with fp_addr_i not pending SHALL fire an assertion; result still written.
REQ-022 Total FIFO capacity SHALL be FifoDepth; overflow impossible by REQ-012.

Reset
REQ-023 While rst_ni=0 at an edge: FIFO emptied, pointers and count 0, all scoreboard bits cleared.
REQ-024 While rst_ni=0: we_a_o=0, fp_ready_o=0, issue_ready_o=0, hazards 0, fp_pending_o=0.
REQ-025 Reset mid-operation SHALL discard buffered FP results without writing them; first cycle after release fp_ready_o=1.

Configuration
REQ-026 Macro IBEX_RF_WB_BYPASS_EN defined: FP result accepted with FIFO empty and no int write SHALL be written the same cycle, not buffered.
REQ-027 Macro undefined: every FP result SHALL pass through the FIFO; minimum acceptance-to-write latency one cycle.

Verification
REQ-028 Int write x5=0xDEADBEEF, idle FP -> same cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF.
REQ-029 Issue rd=7, then FP result x7=0x3F800000 with int idle -> hazard_a_o=1 for raddr 7 until write; write same cycle (bypass) or next (no bypass); hazard 0 after.
REQ-030 FP results x8, x9 accepted while int writes 3 consecutive cycles -> fp_ready_o=0 after 2 accepts, x8 then x9 written after int burst, in order.
REQ-031 Issue rd=10 twice back-to-back -> second cycle issue_ready_o=0 until x10 FP write commits.
REQ-032 Buffer holds 2 entries, rst_ni=0 one cycle -> no write of buffered data, fp_pending_o=0, all hazards 0.
REQ-033 Issue rd=0 -> no pending bit, hazard for raddr 0 stays 0, fp_pending_o stays 0.
